// File: rtl/circuit2_sched_pkg.sv
// circuit2_sched_pkg: shared width default and scheduler state encoding
package circuit2_sched_pkg;
  localparam int DATAWIDTH_DEF = 32;
  typedef enum logic [2:0] {IDLE, S_D, S_E, S_F, S_CMP, S_DONE} state_t;
endpackage

// File: rtl/sched_alu.sv
// sched_alu: shared signed add/sub unit with signed less-than and equality compare
module sched_alu #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] op_a_i,
  input  logic signed [W-1:0] op_b_i,
  input  logic                sub_i,
  output logic signed [W-1:0] res_o,
  output logic                lt_o,
  output logic                eq_o
);
  assign res_o = sub_i ? op_a_i - op_b_i : op_a_i + op_b_i;
  assign lt_o  = op_a_i < op_b_i;
  assign eq_o  = op_a_i == op_b_i;
endmodule

// File: rtl/circuit2_sched.sv
// circuit2_sched: FSM-scheduled datapath sharing one add/sub unit and one comparator
module circuit2_sched
  import circuit2_sched_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  output logic                        Busy,
  output logic                        Done,
  output logic signed [DATAWIDTH-1:0] x,
  output logic signed [DATAWIDTH-1:0] z
);
  state_t state_q, state_d;
  logic ph_q, ph_d, lt_q, lt_d, eq_q, eq_d;
  logic signed [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d, f_q, f_d;
  logic signed [DATAWIDTH-1:0] g_q, g_d, h_q, h_d, x_q, x_d, z_q, z_d;
  logic signed [DATAWIDTH-1:0] alu_a, alu_b, alu_res;
  logic alu_sub, alu_lt, alu_eq;
  assign alu_a   = (state_q == S_CMP) ? d_q : a_q;
  assign alu_b   = (state_q == S_E) ? c_q : (state_q == S_CMP) ? e_q : b_q;
  assign alu_sub = state_q == S_F;
  sched_alu #(.W(DATAWIDTH)) u_alu (
    .op_a_i(alu_a),
    .op_b_i(alu_b),
    .sub_i (alu_sub),
    .res_o (alu_res),
    .lt_o  (alu_lt),
    .eq_o  (alu_eq)
  );
  // S_CMP takes two cycles: ph_q=0 compares and selects g/h, ph_q=1 shifts into x/z
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    g_d     = g_q;
    h_d     = h_q;
    x_d     = x_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: if (Start) begin
        state_d = S_D;
        a_d     = a;
        b_d     = b;
        c_d     = c;
      end
      S_D: begin
        d_d     = alu_res;
        state_d = S_E;
      end
      S_E: begin
        e_d     = alu_res;
        state_d = S_F;
      end
      S_F: begin
        f_d     = alu_res;
        state_d = S_CMP;
      end
      S_CMP: if (!ph_q) begin
        lt_d = alu_lt;
        eq_d = alu_eq;
        g_d  = alu_lt ? e_q : d_q;
        h_d  = alu_eq ? f_q : (alu_lt ? e_q : d_q);
        ph_d = 1'b1;
      end else begin
        x_d     = g_q << lt_q;
        z_d     = h_q >>> eq_q;
        ph_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      g_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      g_q     <= g_d;
      h_q     <= h_d;
      x_q     <= x_d;
      z_q     <= z_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Done = state_q == S_DONE;
  assign x    = x_q;
  assign z    = z_q;
endmodule

// File: tb/tb_circuit2_sched.sv
// tb_circuit2_sched: scoreboard bench for circuit2_sched covering latency, wrap, reset abort and back-to-back
module tb_circuit2_sched;
  logic Clk, Rst, Start, Busy, Done;
  logic signed [31:0] a, b, c, x, z;
  logic [63:0] exp_q[$];
  logic [63:0] prev;
  int tests = 0;
  int fails = 0;

  circuit2_sched #(.DATAWIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
    .Busy(Busy), .Done(Done), .x(x), .z(z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic signed [31:0] ai, bi, ci);
    logic signed [31:0] d, e, f, g, h, xo, zo;
    logic lt, eq;
    d  = ai + bi;
    e  = ai + ci;
    f  = ai - bi;
    lt = d < e;
    eq = d == e;
    g  = lt ? e : d;
    h  = eq ? f : g;
    xo = g << lt;
    zo = h >>> eq;
    return {xo, zo};
  endfunction

  task automatic test_reset();
    Rst = 1'b0;
    Start = 1'b1;
    a = $urandom; b = $urandom; c = $urandom;
    repeat (2) @(negedge Clk);
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", Done); end
    tests++; if (x !== 32'd0) begin fails++; $display("FAIL reset_x got %h want 0", x); end
    tests++; if (z !== 32'd0) begin fails++; $display("FAIL reset_z got %h want 0", z); end
    Start = 1'b0;
    Rst = 1'b1;
    prev = 64'd0;
    @(negedge Clk);
  endtask

  task automatic run_req(input logic signed [31:0] ai, bi, ci, input string name);
    int n;
    logic seen;
    logic [63:0] e;
    exp_q.push_back(model(ai, bi, ci));
    a = ai; b = bi; c = ci;
    Start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge Clk);
      n++;
      if (n <= 4) begin
        a = $urandom; b = $urandom; c = $urandom;
      end else Start = 1'b0;
      if (n == 3) begin
        tests++;
        if ({x, z} !== prev) begin fails++; $display("FAIL %s hold got %h want %h", name, {x, z}, prev); end
      end
      seen = Done;
    end
    Start = 1'b0;
    tests++;
    if (!seen || n != 6) begin fails++; $display("FAIL %s latency got %0d seen=%b want 6", name, n, seen); end
    e = exp_q.pop_front();
    tests++;
    if ({x, z} !== e) begin fails++; $display("FAIL %s result got x=%h z=%h want x=%h z=%h", name, x, z, e[63:32], e[31:0]); end
    @(negedge Clk);
    tests++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin fails++; $display("FAIL %s pulse got done=%b busy=%b want 0 0", name, Done, Busy); end
    repeat (2) @(negedge Clk);
    tests++;
    if ({x, z} !== e) begin fails++; $display("FAIL %s persist got %h want %h", name, {x, z}, e); end
    prev = e;
  endtask

  task automatic test_vectors();
    run_req(32'sd5, 32'sd3, 32'sd1, "v531");
    run_req(32'sd1, 32'sd2, 32'sd4, "v124");
    run_req(32'sd2, 32'sd3, 32'sd3, "v233_eq");
    run_req(32'sh7FFFFFFF, 32'sd1, 32'sd0, "v_wrap");
    for (int i = 0; i < 4; i++) run_req($urandom, $urandom, $urandom, "v_rand");
    run_req(32'sd7, 32'sd0, 32'sd0, "v_eq_zero");
  endtask

  task automatic test_reset_abort();
    int nd;
    a = 32'sd9; b = 32'sd4; c = 32'sd2;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    tests++;
    if (Busy !== 1'b0 || Done !== 1'b0 || x !== 32'd0 || z !== 32'd0) begin
      fails++; $display("FAIL abort_clear got busy=%b done=%b x=%h z=%h want 0 0 0 0", Busy, Done, x, z);
    end
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    tests++;
    if (nd != 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", nd); end
    Rst = 1'b1;
    prev = 64'd0;
    @(negedge Clk);
    run_req(32'sd5, 32'sd3, 32'sd1, "after_abort");
  endtask

  task automatic test_back_to_back();
    int ndone, last;
    logic [63:0] e;
    logic signed [31:0] ra, rb, rc;
    ndone = 0;
    last = -1;
    for (int i = 0; i < 80; i++) begin
      if (Done) begin
        ndone++;
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_unexpected_done at %0d want none", i); end
        else begin
          e = exp_q.pop_front();
          if ({x, z} !== e) begin fails++; $display("FAIL b2b_result got %h want %h", {x, z}, e); end
        end
        if (last >= 0) begin
          tests++;
          if (i - last != 7) begin fails++; $display("FAIL b2b_period got %0d want 7", i - last); end
        end
        last = i;
      end
      if (i < 60) begin
        ra = $urandom; rb = $urandom; rc = $urandom;
        a = ra; b = rb; c = rc;
        Start = 1'b1;
        if (!Busy) exp_q.push_back(model(ra, rb, rc));
      end else Start = 1'b0;
      @(negedge Clk);
    end
    tests++;
    if (ndone != 9 || exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_count got %0d done, %0d pending want 9, 0", ndone, exp_q.size());
    end
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; a = '0; b = '0; c = '0;
    prev = 64'd0;
    test_reset();
    test_vectors();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
